// File: rtl/fifo_mem_pkg.sv
// Shared defaults and the depth-to-capacity mapping for the FIFO-mode memory responder.
package fifo_mem_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_ACNT_WIDTH = 4;

  // A depth of 0, or one beyond the physical array, selects the full array.
  function automatic int unsigned cap_from_depth(input logic [15:0] depth,
                                                 input int unsigned addr_width);
    int unsigned max_words;
    int unsigned d;
    max_words = 32'd1 << addr_width;
    d         = 32'(depth);
    return ((d == 0) || (d > max_words)) ? max_words : d;
  endfunction

endpackage

// File: rtl/fifo_mem_ram.sv
// Simple dual-port array: synchronous write, registered read gated by a read enable.
module fifo_mem_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_mem_responder.sv
// Reference FIFO-mode memory responder: pointers, occupancy counter, flags and read-valid strobe.
module fifo_mem_responder
  import fifo_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACNT_WIDTH = DEF_ACNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  wen_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [15:0]           depth,
  input  logic [ACNT_WIDTH-1:0] almost_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   num_words
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         count, cap, acnt, af_thresh;
  logic [CW-1:0]         wr_inc, rd_inc;
  logic                  wr_acc, rd_acc;

  assign cap  = CW'(cap_from_depth(depth, ADDR_WIDTH));
  assign acnt = CW'(almost_count);

  assign full         = (count >= cap);
  assign empty        = (count == '0);
  assign af_thresh    = (cap > acnt) ? (cap - acnt) : '0;
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= acnt);
  assign num_words    = count;

  // Flush wins over any same-cycle request, so neither side may touch the array or the read register.
  assign wr_acc = clk_en && wen_in && !full  && !flush;
  assign rd_acc = clk_en && ren_in && !empty && !flush;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wr_inc     = {1'b0, wr_ptr} + CW'(1);
    rd_inc     = {1'b0, rd_ptr} + CW'(1);
    wr_ptr_nxt = wr_inc[ADDR_WIDTH-1:0];
    rd_ptr_nxt = rd_inc[ADDR_WIDTH-1:0];
    if (wr_inc >= cap) wr_ptr_nxt = '0;
    if (rd_inc >= cap) rd_ptr_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
    end else if (clk_en) begin
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      valid_out <= rd_acc;
    end
  end

  fifo_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule
